// File: rtl/btb_pkg.sv
// Shared types, constants and address-split helpers for the branch target buffer.
package btb_pkg;

    localparam int BTB_DATA_W  = 64;
    localparam int BTB_ENTRIES = 16;
    localparam int BTB_TAG_W   = 12;
    localparam int BTB_CTR_W   = 2;
    localparam int BTB_PERF_W  = 32;

    // Helpers work on a fixed-width PC and return fixed-width results.
    // Callers size-cast the result down to their own widths.
    localparam int PC_MAX_W  = 64;
    localparam int IDX_MAX_W = 8;

    // Architectural entry in the default build. The top re-declares the
    // entry at its own parameter widths.
    typedef struct packed {
        logic                  valid;
        logic [BTB_TAG_W-1:0]  tag;
        logic [BTB_DATA_W-1:0] target;
        logic [BTB_CTR_W-1:0]  ctr;
    } btb_entry_t;

    // Allocation value: MSB set, all other bits clear (weakly taken).
    function automatic logic [3:0] ctr_weak_taken(input int ctr_w);
        return 4'(1 << (ctr_w - 1));
    endfunction

    // Upper saturation value of a direction counter.
    function automatic logic [3:0] ctr_sat_max(input int ctr_w);
        return 4'((1 << ctr_w) - 1);
    endfunction

    // Index is pc[idx_w+1:2]; the byte offset bits are ignored.
    function automatic logic [IDX_MAX_W-1:0] pc_index(input logic [PC_MAX_W-1:0] pc,
                                                      input int idx_w);
        logic [PC_MAX_W-1:0] mask;
        mask = (PC_MAX_W'(1) << idx_w) - PC_MAX_W'(1);
        return IDX_MAX_W'((pc >> 2) & mask);
    endfunction

    // Partial tag is the tag_w bits directly above the index.
    function automatic logic [PC_MAX_W-1:0] pc_tag(input logic [PC_MAX_W-1:0] pc,
                                                   input int idx_w,
                                                   input int tag_w);
        logic [PC_MAX_W-1:0] mask;
        mask = (tag_w >= PC_MAX_W) ? '1 : (PC_MAX_W'(1) << tag_w) - PC_MAX_W'(1);
        return (pc >> (idx_w + 2)) & mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at both ends, with a synchronous load.
module sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value
);

    // Load wins over counting; inc and dec together cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc && !dec && (value != '1)) begin
            value <= value + 1'b1;
        end else if (dec && !inc && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: same-cycle lookup for the fetch PC,
// trained from ID-stage branch resolution, with saturating perf counters.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int DATA_W  = BTB_DATA_W,
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int TAG_W   = BTB_TAG_W,
    parameter int CTR_W   = BTB_CTR_W,
    parameter int PERF_W  = BTB_PERF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] if_pc,
    output logic              hit,
    output logic              predict_taken,
    output logic [DATA_W-1:0] predict_pc,
    input  logic              upd_valid,
    input  logic [DATA_W-1:0] upd_pc,
    input  logic [DATA_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    input  logic              flush_all,
    output logic [PERF_W-1:0] perf_lookups,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_weak_taken(CTR_W));

    // Direction counters live in sat_counter instances; the rest is here.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] target;
    } slot_t;

    slot_t            table_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic             upd_en;
    logic             upd_hit;
    logic             do_alloc;
    logic             do_train;

    assign rd_idx = IDX_W'(pc_index(PC_MAX_W'(if_pc), IDX_W));
    assign rd_tag = TAG_W'(pc_tag(PC_MAX_W'(if_pc), IDX_W, TAG_W));
    assign wr_idx = IDX_W'(pc_index(PC_MAX_W'(upd_pc), IDX_W));
    assign wr_tag = TAG_W'(pc_tag(PC_MAX_W'(upd_pc), IDX_W, TAG_W));

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign hit           = table_q[rd_idx].valid && (table_q[rd_idx].tag == rd_tag);
    assign predict_taken = hit && ctr_q[rd_idx][CTR_W-1];
    assign predict_pc    = predict_taken ? table_q[rd_idx].target : '0;

    // flush_all suppresses any training in the same cycle.
    assign upd_en   = enable && upd_valid && !flush_all;
    assign upd_hit  = table_q[wr_idx].valid && (table_q[wr_idx].tag == wr_tag);
    assign do_alloc = upd_en && !upd_hit && upd_taken;
    assign do_train = upd_en && upd_hit;

    // Valid/tag/target storage: flush clears valid bits only, allocation
    // overwrites the whole slot, a taken hit refreshes the target.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (enable) begin
            if (flush_all) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    table_q[i].valid <= 1'b0;
                end
            end else if (do_alloc) begin
                table_q[wr_idx].valid  <= 1'b1;
                table_q[wr_idx].tag    <= wr_tag;
                table_q[wr_idx].target <= upd_target;
            end else if (do_train && upd_taken) begin
                table_q[wr_idx].target <= upd_target;
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic sel;
        assign sel = (wr_idx == IDX_W'(g));

        sat_counter #(.W(CTR_W)) u_ctr (
            .clk      (clk),
            .reset    (reset),
            .inc      (do_train && upd_taken && sel),
            .dec      (do_train && !upd_taken && sel),
            .load     (do_alloc && sel),
            .load_val (CTR_ALLOC),
            .value    (ctr_q[g])
        );
    end

    sat_counter #(.W(PERF_W)) u_perf_lookups (
        .clk      (clk),
        .reset    (reset),
        .inc      (enable),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .value    (perf_lookups)
    );

    sat_counter #(.W(PERF_W)) u_perf_mispredicts (
        .clk      (clk),
        .reset    (reset),
        .inc      (enable && upd_valid && upd_mispredict),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .value    (perf_mispredicts)
    );

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench: behavioural table model compared on every cycle,
// directed sequences with literal expectations, then randomized traffic.
module tb_branch_target_buffer;

    localparam int DATA_W   = 64;
    localparam int ENTRIES  = 16;
    localparam int TAG_W    = 12;
    localparam int CTR_W    = 2;
    localparam int PERF_W   = 4;
    localparam int PERF_MAX = 15;
    localparam int CTR_MAX  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [DATA_W-1:0] if_pc;
    logic              hit;
    logic              predict_taken;
    logic [DATA_W-1:0] predict_pc;
    logic              upd_valid;
    logic [DATA_W-1:0] upd_pc;
    logic [DATA_W-1:0] upd_target;
    logic              upd_taken;
    logic              upd_mispredict;
    logic              flush_all;
    logic [PERF_W-1:0] perf_lookups;
    logic [PERF_W-1:0] perf_mispredicts;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [63:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int          m_look;
    int          m_mis;

    branch_target_buffer #(
        .DATA_W (DATA_W),
        .ENTRIES(ENTRIES),
        .TAG_W  (TAG_W),
        .CTR_W  (CTR_W),
        .PERF_W (PERF_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .if_pc           (if_pc),
        .hit             (hit),
        .predict_taken   (predict_taken),
        .predict_pc      (predict_pc),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_taken       (upd_taken),
        .upd_mispredict  (upd_mispredict),
        .flush_all       (flush_all),
        .perf_lookups    (perf_lookups),
        .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [63:0] pc);
        return int'((pc / (4 * ENTRIES)) % (1 << TAG_W));
    endfunction

    function automatic logic m_hit(input logic [63:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic logic m_pt(input logic [63:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= (1 << (CTR_W - 1)));
    endfunction

    function automatic logic [63:0] m_ppc(input logic [63:0] pc);
        return m_pt(pc) ? m_target[idx_of(pc)] : 64'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table rules applied on each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i]  = 1'b0;
                m_tag[i]    = 0;
                m_target[i] = 64'd0;
                m_ctr[i]    = 0;
            end
            m_look = 0;
            m_mis  = 0;
        end else if (enable) begin
            if (m_look < PERF_MAX) m_look = m_look + 1;
            if (upd_valid && upd_mispredict && (m_mis < PERF_MAX)) m_mis = m_mis + 1;
            if (flush_all) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            end else if (upd_valid) begin
                int          ui;
                int unsigned ut;
                ui = idx_of(upd_pc);
                ut = tag_of(upd_pc);
                if (m_valid[ui] && (m_tag[ui] == ut)) begin
                    if (upd_taken) begin
                        m_ctr[ui]    = (m_ctr[ui] < CTR_MAX) ? m_ctr[ui] + 1 : CTR_MAX;
                        m_target[ui] = upd_target;
                    end else begin
                        m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    m_valid[ui]  = 1'b1;
                    m_tag[ui]    = ut;
                    m_target[ui] = upd_target;
                    m_ctr[ui]    = 1 << (CTR_W - 1);
                end
            end
        end
    end

    // Compare every cycle, mid-period, against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("hit", {63'd0, hit}, {63'd0, m_hit(if_pc)});
            check("predict_taken", {63'd0, predict_taken}, {63'd0, m_pt(if_pc)});
            check("predict_pc", predict_pc, m_ppc(if_pc));
            check("perf_lookups", 64'(perf_lookups), 64'(m_look));
            check("perf_mispredicts", 64'(perf_mispredicts), 64'(m_mis));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        upd_valid      = 1'b0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        flush_all      = 1'b0;
    endtask

    task automatic look(input logic [63:0] pc);
        idle();
        if_pc = pc;
        #1;
    endtask

    task automatic train(input logic [63:0] pc, input logic [63:0] tgt, input logic tk, input int n);
        for (int k = 0; k < n; k++) begin
            upd_valid  = 1'b1;
            upd_pc     = pc;
            upd_target = tgt;
            upd_taken  = tk;
            step();
        end
        idle();
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] pc;
        pc = (64'($urandom_range(1, 3)) << 6) | (64'($urandom_range(0, ENTRIES - 1)) << 2)
           | 64'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) pc = pc | (64'd1 << 40);
        return pc;
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b1; if_pc = 64'h100;
        upd_pc = 64'd0; upd_target = 64'd0;
        idle();
        step();
        step();
        reset  = 1'b0;
        chk_on = 1'b1;

        look(64'h100);
        check("rst_hit", {63'd0, hit}, 64'd0);
        check("rst_pt", {63'd0, predict_taken}, 64'd0);
        check("rst_ppc", predict_pc, 64'd0);
        check("rst_perf_l", 64'(perf_lookups), 64'd0);
        check("rst_perf_m", 64'(perf_mispredicts), 64'd0);

        train(64'h100, 64'h40, 1'b1, 1);
        look(64'h100);
        check("alloc_hit", {63'd0, hit}, 64'd1);
        check("alloc_pt", {63'd0, predict_taken}, 64'd1);
        check("alloc_ppc", predict_pc, 64'h40);

        train(64'h100, 64'h40, 1'b0, 2);
        look(64'h100);
        check("nt2_hit", {63'd0, hit}, 64'd1);
        check("nt2_pt", {63'd0, predict_taken}, 64'd0);

        train(64'h100, 64'h40, 1'b0, 1);
        train(64'h100, 64'h40, 1'b1, 1);
        look(64'h100);
        check("sat0_pt", {63'd0, predict_taken}, 64'd0);

        train(64'h100, 64'h88, 1'b1, 4);
        look(64'h100);
        check("sat3_pt", {63'd0, predict_taken}, 64'd1);
        check("sat3_ppc", predict_pc, 64'h88);
        train(64'h100, 64'h88, 1'b0, 2);
        look(64'h100);
        check("sat3_down_pt", {63'd0, predict_taken}, 64'd0);

        train(64'h140, 64'h200, 1'b1, 1);
        look(64'h100);
        check("alias_old_hit", {63'd0, hit}, 64'd0);
        look(64'h140);
        check("alias_new_hit", {63'd0, hit}, 64'd1);
        check("alias_new_ppc", predict_pc, 64'h200);

        if_pc = 64'h180; upd_valid = 1'b1; upd_pc = 64'h180;
        upd_target = 64'h300; upd_taken = 1'b1;
        #1;
        check("same_cycle_hit", {63'd0, hit}, 64'd0);
        step();
        look(64'h180);
        check("after_upd_ppc", predict_pc, 64'h300);

        flush_all = 1'b1; upd_valid = 1'b1; upd_pc = 64'h1C0;
        upd_target = 64'h500; upd_taken = 1'b1;
        step();
        look(64'h180);
        check("flush_hit_180", {63'd0, hit}, 64'd0);
        look(64'h1C0);
        check("flush_upd_dropped", {63'd0, hit}, 64'd0);

        for (int k = 0; k < 3; k++) begin
            upd_valid = 1'b1; upd_mispredict = 1'b1; upd_taken = 1'b0; upd_pc = 64'h3000;
            step();
        end
        idle();
        #1;
        check("mis_3", 64'(perf_mispredicts), 64'd3);
        enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            upd_valid = 1'b1; upd_mispredict = 1'b1; upd_taken = 1'b1; upd_pc = 64'h100;
            step();
        end
        look(64'h100);
        check("mis_hold", 64'(perf_mispredicts), 64'd3);
        check("disabled_no_alloc", {63'd0, hit}, 64'd0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("midrst_perf_l", 64'(perf_lookups), 64'd0);
        check("midrst_perf_m", 64'(perf_mispredicts), 64'd0);
        enable = 1'b1;
        for (int k = 0; k < 20; k++) step();
        #1;
        check("lookups_sat", 64'(perf_lookups), 64'd15);

        for (int k = 0; k < 600; k++) begin
            reset          = ($urandom_range(0, 127) == 0);
            enable         = ($urandom_range(0, 7) != 0);
            flush_all      = ($urandom_range(0, 31) == 0);
            upd_valid      = ($urandom_range(0, 1) == 1);
            upd_taken      = ($urandom_range(0, 2) != 0);
            upd_mispredict = ($urandom_range(0, 3) == 0);
            upd_pc         = rand_pc();
            upd_target     = {$urandom, $urandom};
            if_pc          = rand_pc();
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
